vga_pixel_out: RTL
==================

Name: vga_pixel_out

Overview:
- Downstream consumer of the video byte buffer.
- Generates VGA 640x480@60 timing from the 25 MHz pixel clock.
- Raises need_pixel to pull one RGB332 byte per active pixel from the buffer, then drives registered RGB and sync lines to the DAC/connector.
- Detects buffer underrun: the buffer is empty when a pixel is requested.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low pulses)

Ports:
- clk25MHz  in  1  pixel clock
- rst  in  1  asynchronous active-low reset
- en  in  1  global enable; low freezes the block
- video  in  8  RGB332 byte from buffer; valid the cycle after need_pixel
- full  in  1  buffer holds data
- clr_underrun  in  1  clears sticky underrun flag
- need_pixel  out  1  pixel request to buffer
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- red  out  3  red component, video[7:5]
- green  out  3  green component, video[4:2]
- blue  out  2  blue component, video[1:0]
- active  out  1  RGB outputs are in visible area
- frame_start  out  1  one-cycle pulse with first visible pixel output
- underrun  out  1  sticky: a request was made while buffer empty

Behaviour:
- Reset (rst low, async): hcount=0, vcount=0, all pipeline stages cleared.
  - Outputs: need_pixel=0, rgb=0, active=0, frame_start=0, underrun=0, hsync=vsync=~SYNC_POL.
- Counters:
  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - hcount runs 0..H_TOTAL-1 and wraps to 0. vcount increments on the hcount wrap and wraps 0..V_TOTAL-1.
  - Counter widths are 10 bits, sized by clog2 of the totals.
- Stage 0 (combinational from counters):
  - vis = hcount<H_ACTIVE && vcount<V_ACTIVE.
  - need_pixel = vis && en.
  - hs0 asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - vs0 asserted for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC.
- Stage 1 register: the buffer returns the byte one cycle after need_pixel. Register vis1, hs1, vs1, first1=(hcount==0&&vcount==0), and ok1=full sampled with the request.
- Stage 2 register (outputs), total latency 2 clocks from counter position to pins:
  - active=vis1.
  - rgb = (vis1 && ok1) ? video fields : 0.
  - hsync/vsync = asserted level when hs1/vs1, else ~SYNC_POL.
  - frame_start = first1 && vis1.
- Underrun:
  - need_pixel with full==0 -> that pixel outputs black and underrun sets.
  - underrun holds until clr_underrun=1. If set and clear happen in the same cycle, set wins.
- Enable:
  - en=0 holds counters and all pipeline registers (outputs frozen) and forces need_pixel=0.
  - Resuming en continues from the held position with no skipped or duplicated pixel.
- Reset mid-line: all state returns to reset values at once. The first pixel after release is (0,0).
- Request count is exactly H_ACTIVE per visible line and 0 during blanking lines.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants (H_*/V_*, totals);
  - RGB332 field positions/widths (R 7:5, G 4:2, B 1:0);
  - sync polarity localparams.
- One sub-module: vga_timing_gen, containing the h/v counters, vis, and raw hs0/vs0/first flags with the en hold.
- vga_pixel_out instantiates it and adds the request, pipeline, colour split and underrun logic.

Test Plan:
- Reset release, en=1, full=1, video=8'hE3 constant -> hsync low for 96 clocks every 800.
  - First hsync falling edge at clock 658 after release (656+2 latency).
  - vsync low 2 lines (1600 clocks) every 420000 clocks.
- Per-line count -> need_pixel high 640 consecutive clocks per visible line, 0 in lines 480..524.
  - active is need_pixel delayed 2 clocks.
  - red=3'b111, green=3'b000, blue=2'b11 only while active.
- Drop full=0 for one requested pixel at (100,10) -> that pixel rgb=0, neighbours 8'hE3 colours, underrun=1.
  - underrun stays set until clr_underrun pulse; set and clear in the same cycle leaves underrun=1.
- en low 37 clocks mid-line at hcount=300 -> outputs frozen, need_pixel=0.
  - After resume, pixel sequence continues at 300 (verify with an incrementing video pattern).
- Assert rst at hcount=500, vcount=200 -> outputs immediately at reset values.
  - After release, frame_start pulses 2 clocks later, then hsync timing restarts from 0.
- SYNC_POL=1 build -> hsync/vsync idle low and pulse high with the same widths and positions.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, RGB332 field layout and sync polarity helpers.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  typedef struct packed {
    logic [R_MSB-R_LSB:0] r;
    logic [G_MSB-G_LSB:0] g;
    logic [B_MSB-B_LSB:0] b;
  } rgb332_t;

  function automatic rgb332_t split_rgb332(input logic [7:0] px);
    rgb332_t c;
    c.r = px[R_MSB:R_LSB];
    c.g = px[G_MSB:G_LSB];
    c.b = px[B_MSB:B_LSB];
    return c;
  endfunction

  function automatic logic sync_level(input logic asserted, input bit pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with enable hold, decoded into visible, sync and frame-origin flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic vis,
  output logic hs,
  output logic vs,
  output logic first
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (en) begin
      if (hcount == HW'(H_TOTAL - 1)) begin
        hcount <= '0;
        vcount <= (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + VW'(1);
      end else begin
        hcount <= hcount + HW'(1);
      end
    end
  end

  assign vis   = (hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_ACTIVE));
  assign hs    = (hcount >= HW'(H_ACTIVE + H_FP)) && (hcount < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs    = (vcount >= VW'(V_ACTIVE + V_FP)) && (vcount < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign first = (hcount == '0) && (vcount == '0);

endmodule

// File: rtl/vga_pixel_out.sv
// VGA output stage: requests one RGB332 byte per visible pixel, pipelines it to registered pins, flags underruns.
module vga_pixel_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic       clk25MHz,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] video,
  input  logic       full,
  input  logic       clr_underrun,
  output logic       need_pixel,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       active,
  output logic       frame_start,
  output logic       underrun
);

  logic vld_p0, hs_p0, vs_p0, first_p0;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk  (clk25MHz),
    .rst  (rst),
    .en   (en),
    .vis  (vld_p0),
    .hs   (hs_p0),
    .vs   (vs_p0),
    .first(first_p0)
  );

  // Stage 0: request goes out combinationally with the counter position
  assign need_pixel = vld_p0 && en && rst;

  // Stage 1: flags aligned with the byte the buffer returns this cycle
  logic vld_p1, hs_p1, vs_p1, first_p1, ok_p1, req_p1;
  logic       hold_vld;
  logic [7:0] vid_hold;
  logic [7:0] pix_p1;
  rgb332_t    col_p1;

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
      first_p1 <= 1'b0;
      ok_p1    <= 1'b0;
    end else if (en) begin
      vld_p1   <= vld_p0;
      hs_p1    <= hs_p0;
      vs_p1    <= vs_p0;
      first_p1 <= first_p0;
      ok_p1    <= full;
    end
  end

  // A byte arriving while frozen would be gone on resume, so park it until en returns.
  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      req_p1   <= 1'b0;
      hold_vld <= 1'b0;
      vid_hold <= '0;
    end else begin
      req_p1 <= need_pixel;
      if (en) begin
        hold_vld <= 1'b0;
      end else if (req_p1) begin
        hold_vld <= 1'b1;
        vid_hold <= video;
      end
    end
  end

  assign pix_p1 = hold_vld ? vid_hold : video;
  assign col_p1 = split_rgb332(pix_p1);

  // Stage 2: registered pins
  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      active      <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else if (en) begin
      active <= vld_p1;
      if (vld_p1 && ok_p1) begin
        red   <= col_p1.r;
        green <= col_p1.g;
        blue  <= col_p1.b;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
      hsync       <= sync_level(hs_p1, SYNC_POL);
      vsync       <= sync_level(vs_p1, SYNC_POL);
      frame_start <= first_p1 && vld_p1;
    end
  end

  // Sticky underrun; a new underrun beats a simultaneous clear
  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      underrun <= 1'b0;
    end else if (need_pixel && !full) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule
